// File: rtl/ann_pkg.sv
// Shared widths and FSM state encodings for the ANN datapath.
// The MAC and the later classification stages reuse these defaults.
package ann_pkg;

  localparam int P_W         = 20;
  localparam int NUM_CLASSES = 10;
  localparam int IDX_W       = 4;
  localparam int CNT_W       = 8;

  localparam logic [1:0] S_FIRST = 2'd0;
  localparam logic [1:0] S_REST  = 2'd1;
  localparam logic [1:0] S_LAST  = 2'd2;

endpackage

// File: rtl/signed_max_sel.sv
// Combinational signed max selector: the candidate wins only when strictly
// greater, so on a tie the incumbent (lower index) is kept.
module signed_max_sel #(
  parameter int P_W   = ann_pkg::P_W,
  parameter int IDX_W = ann_pkg::IDX_W
) (
  input  logic [0:P_W-1]   cand_score,
  input  logic [0:IDX_W-1] cand_idx,
  input  logic [0:P_W-1]   inc_score,
  input  logic [0:IDX_W-1] inc_idx,
  output logic [0:P_W-1]   win_score,
  output logic [0:IDX_W-1] win_idx
);

  logic take;

  always_comb begin
    take      = $signed(cand_score) > $signed(inc_score);
    win_score = take ? cand_score : inc_score;
    win_idx   = take ? cand_idx   : inc_idx;
  end

endmodule

// File: rtl/mac_argmax.sv
// Running argmax over NUM_CLASSES consecutive MAC scores per digit, with a
// one-entry valid/ready result register and a digit counter.
module mac_argmax #(
  parameter int P_W         = ann_pkg::P_W,
  parameter int NUM_CLASSES = ann_pkg::NUM_CLASSES,
  parameter int IDX_W       = ann_pkg::IDX_W,
  parameter int CNT_W       = ann_pkg::CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             p_valid,
  output logic             p_ready,
  input  logic [0:P_W-1]   p,
  output logic             class_valid,
  input  logic             class_ready,
  output logic [0:IDX_W-1] class_idx,
  output logic [0:P_W-1]   class_score,
  output logic [0:CNT_W-1] digit_cnt
);

  import ann_pkg::*;

  localparam logic [0:IDX_W-1] LAST_IDX = IDX_W'(NUM_CLASSES - 1);

  logic [1:0]       state;
  logic [0:IDX_W-1] idx;
  logic [0:IDX_W-1] idx_inc;
  logic [0:P_W-1]   best;
  logic [0:IDX_W-1] best_idx;
  logic [0:P_W-1]   win_score;
  logic [0:IDX_W-1] win_idx;
  logic             accept;
  logic             load;

  // Stall only when finishing a digit would overwrite an unaccepted result.
  assign p_ready = !((state == S_LAST) && class_valid && !class_ready);
  assign accept  = p_valid && p_ready;
  assign load    = accept && (state == S_LAST);
  assign idx_inc = idx + IDX_W'(1);

  // Same selector serves the running update and the final compare in S_LAST.
  signed_max_sel #(
    .P_W   (P_W),
    .IDX_W (IDX_W)
  ) u_sel (
    .cand_score (p),
    .cand_idx   (idx),
    .inc_score  (best),
    .inc_idx    (best_idx),
    .win_score  (win_score),
    .win_idx    (win_idx)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_FIRST;
      idx      <= '0;
      best     <= '0;
      best_idx <= '0;
    end else if (accept) begin
      case (state)
        S_FIRST: begin
          best     <= p;
          best_idx <= '0;
          idx      <= IDX_W'(1);
          state    <= (NUM_CLASSES == 2) ? S_LAST : S_REST;
        end
        S_REST: begin
          best     <= win_score;
          best_idx <= win_idx;
          idx      <= idx_inc;
          if (idx_inc == LAST_IDX) state <= S_LAST;
        end
        default: begin
          idx   <= '0;
          state <= S_FIRST;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      class_valid <= 1'b0;
      class_idx   <= '0;
      class_score <= '0;
      digit_cnt   <= '0;
    end else if (load) begin
      class_valid <= 1'b1;
      class_idx   <= win_idx;
      class_score <= win_score;
      digit_cnt   <= digit_cnt + CNT_W'(1);
    end else if (class_ready) begin
      class_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mac_argmax.sv
// Directed self-checking bench for mac_argmax (10 classes, 20-bit scores).
module tb_mac_argmax;

  localparam int P_W   = 20;
  localparam int NC    = 10;
  localparam int IDX_W = 4;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             p_valid;
  logic             p_ready;
  logic [0:P_W-1]   p;
  logic             class_valid;
  logic             class_ready;
  logic [0:IDX_W-1] class_idx;
  logic [0:P_W-1]   class_score;
  logic [0:CNT_W-1] digit_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  int basic_v [NC] = '{5, -3, 12, 0, 7, 12, 1, 2, 3, 4};

  always #5 clk = ~clk;

  mac_argmax #(
    .P_W         (P_W),
    .NUM_CLASSES (NC),
    .IDX_W       (IDX_W),
    .CNT_W       (CNT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .p_valid     (p_valid),
    .p_ready     (p_ready),
    .p           (p),
    .class_valid (class_valid),
    .class_ready (class_ready),
    .class_idx   (class_idx),
    .class_score (class_score),
    .digit_cnt   (digit_cnt)
  );

  // Presents one score and returns 1 time unit after the edge that accepted it.
  task automatic send(input int v);
    int guard;
    guard   = 0;
    p       = 20'(v);
    p_valid = 1'b1;
    @(negedge clk);
    while (!p_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    n_checks++;
    if (p_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL send_timeout: p_ready=%0b required 1", p_ready);
    end
    @(posedge clk);
    #1;
    p_valid = 1'b0;
    p       = 20'h5A5A5;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    @(negedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic test_reset();
    class_ready = 1'b0;
    for (int i = 0; i < NC; i++) send(basic_v[i]);
    @(negedge clk);
    n_checks++;
    if (class_valid !== 1'b1) begin
      n_fail++; $display("FAIL pre_reset_valid: got %0b need 1", class_valid);
    end
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) send(basic_v[i]);
    rst = 1'b0;
    #2;
    n_checks++;
    if (class_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %0b need 0", class_valid); end
    n_checks++;
    if (class_idx !== 4'd0) begin n_fail++; $display("FAIL rst_idx: got %0d need 0", class_idx); end
    n_checks++;
    if (class_score !== 20'd0) begin n_fail++; $display("FAIL rst_score: got %h need 0", class_score); end
    n_checks++;
    if (digit_cnt !== 8'd0) begin n_fail++; $display("FAIL rst_cnt: got %0d need 0", digit_cnt); end
    n_checks++;
    if (p_ready !== 1'b1) begin n_fail++; $display("FAIL rst_p_ready: got %0b need 1", p_ready); end
    @(posedge clk); #1;
    rst         = 1'b1;
    class_ready = 1'b1;
  endtask

  task automatic test_basic();
    for (int i = 0; i < NC - 1; i++) send(basic_v[i]);
    n_checks++;
    if (class_valid !== 1'b0) begin n_fail++; $display("FAIL basic_early_valid: got %0b need 0", class_valid); end
    send(basic_v[NC-1]);
    @(negedge clk);
    n_checks++;
    if (class_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid: got %0b need 1", class_valid); end
    n_checks++;
    if (class_idx !== 4'd2) begin n_fail++; $display("FAIL basic_idx: got %0d need 2", class_idx); end
    n_checks++;
    if (class_score !== 20'd12) begin n_fail++; $display("FAIL basic_score: got %h need 0000c", class_score); end
    n_checks++;
    if (digit_cnt !== 8'd1) begin n_fail++; $display("FAIL basic_cnt: got %0d need 1", digit_cnt); end
    @(posedge clk); #1;
    @(negedge clk);
    n_checks++;
    if (class_valid !== 1'b0) begin n_fail++; $display("FAIL basic_taken: got %0b need 0", class_valid); end
    @(posedge clk); #1;
  endtask

  task automatic test_extremes();
    send('h80000);
    send('hFFFFF);
    send('h80001);
    for (int i = 3; i < NC; i++) send('h80000);
    @(negedge clk);
    n_checks++;
    if (class_valid !== 1'b1) begin n_fail++; $display("FAIL ext_valid: got %0b need 1", class_valid); end
    n_checks++;
    if (class_idx !== 4'd1) begin n_fail++; $display("FAIL ext_idx: got %0d need 1", class_idx); end
    n_checks++;
    if (class_score !== 20'hFFFFF) begin n_fail++; $display("FAIL ext_score: got %h need fffff", class_score); end
    n_checks++;
    if (digit_cnt !== 8'd2) begin n_fail++; $display("FAIL ext_cnt: got %0d need 2", digit_cnt); end
    @(posedge clk); #1;
    for (int i = 0; i < NC; i++) send(7);
    @(negedge clk);
    n_checks++;
    if (class_idx !== 4'd0) begin n_fail++; $display("FAIL equal_idx: got %0d need 0", class_idx); end
    n_checks++;
    if (class_score !== 20'd7) begin n_fail++; $display("FAIL equal_score: got %h need 00007", class_score); end
    n_checks++;
    if (digit_cnt !== 8'd3) begin n_fail++; $display("FAIL equal_cnt: got %0d need 3", digit_cnt); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_pressure();
    int b_v [NC] = '{20, 1, 4, 1, 5, 9, 2, 6, 5, 20};
    do_reset();
    class_ready = 1'b0;
    for (int i = 0; i < NC; i++) send(i);
    @(negedge clk);
    n_checks++;
    if (class_valid !== 1'b1 || class_idx !== 4'd9 || class_score !== 20'd9) begin
      n_fail++; $display("FAIL bp_a_result: valid=%0b idx=%0d score=%h need 1/9/00009", class_valid, class_idx, class_score);
    end
    @(posedge clk); #1;
    for (int i = 0; i < NC - 1; i++) send(b_v[i]);
    p       = 20'(b_v[NC-1]);
    p_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      n_checks++;
      if (p_ready !== 1'b0) begin n_fail++; $display("FAIL bp_stall: p_ready=%0b need 0", p_ready); end
      n_checks++;
      if (class_valid !== 1'b1 || class_idx !== 4'd9 || class_score !== 20'd9) begin
        n_fail++; $display("FAIL bp_hold: valid=%0b idx=%0d score=%h need 1/9/00009", class_valid, class_idx, class_score);
      end
    end
    @(posedge clk); #1;
    class_ready = 1'b1;
    #1;
    n_checks++;
    if (p_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release: p_ready=%0b need 1", p_ready); end
    @(posedge clk); #1;
    p_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (class_valid !== 1'b1) begin n_fail++; $display("FAIL bp_b_valid: got %0b need 1", class_valid); end
    n_checks++;
    if (class_idx !== 4'd0) begin n_fail++; $display("FAIL bp_b_idx: got %0d need 0", class_idx); end
    n_checks++;
    if (class_score !== 20'd20) begin n_fail++; $display("FAIL bp_b_score: got %h need 00014", class_score); end
    n_checks++;
    if (digit_cnt !== 8'd2) begin n_fail++; $display("FAIL bp_b_cnt: got %0d need 2", digit_cnt); end
    @(posedge clk); #1;
  endtask

  // Digit d peaks with 3*d+1 at position d%10; every other score is -d.
  task automatic test_continuous();
    int d;
    int pos;
    int j;
    logic exp_valid;
    do_reset();
    class_ready = 1'b1;
    for (int t = 0; t <= 256 * NC; t++) begin
      if (t < 256 * NC) begin
        d       = t / NC;
        pos     = t % NC;
        p       = (pos == d % NC) ? 20'(3 * d + 1) : 20'(-d);
        p_valid = 1'b1;
      end else begin
        p_valid = 1'b0;
      end
      @(negedge clk);
      exp_valid = (t >= NC) && (t % NC == 0);
      n_checks++;
      if (p_ready !== 1'b1) begin n_fail++; $display("FAIL cont_ready t=%0d: got %0b need 1", t, p_ready); end
      n_checks++;
      if (class_valid !== exp_valid) begin
        n_fail++; $display("FAIL cont_valid t=%0d: got %0b need %0b", t, class_valid, exp_valid);
      end
      if (exp_valid) begin
        j = t / NC - 1;
        n_checks++;
        if (class_idx !== 4'(j % NC) || class_score !== 20'(3 * j + 1)) begin
          n_fail++; $display("FAIL cont_result j=%0d: idx=%0d score=%0d need %0d/%0d", j, class_idx, class_score, j % NC, 3 * j + 1);
        end
        n_checks++;
        if (digit_cnt !== 8'(j + 1)) begin
          n_fail++; $display("FAIL cont_cnt j=%0d: got %0d need %0d", j, digit_cnt, (j + 1) % 256);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid();
    int post_v [NC] = '{1, 2, 3, 4, 5, 6, 50, 8, 9, 0};
    do_reset();
    class_ready = 1'b1;
    for (int i = 0; i < 6; i++) send((i == 3) ? 1000 : 1);
    do_reset();
    for (int i = 0; i < NC - 1; i++) send(post_v[i]);
    n_checks++;
    if (class_valid !== 1'b0) begin n_fail++; $display("FAIL mid_early_valid: got %0b need 0", class_valid); end
    send(post_v[NC-1]);
    @(negedge clk);
    n_checks++;
    if (class_valid !== 1'b1 || class_idx !== 4'd6 || class_score !== 20'd50) begin
      n_fail++; $display("FAIL mid_result: valid=%0b idx=%0d score=%h need 1/6/00032", class_valid, class_idx, class_score);
    end
    n_checks++;
    if (digit_cnt !== 8'd1) begin n_fail++; $display("FAIL mid_cnt: got %0d need 1", digit_cnt); end
    repeat (3) begin
      @(posedge clk); #1;
      @(negedge clk);
      n_checks++;
      if (class_valid !== 1'b0 || digit_cnt !== 8'd1) begin
        n_fail++; $display("FAIL mid_single: valid=%0b cnt=%0d need 0/1", class_valid, digit_cnt);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_gapped();
    do_reset();
    class_ready = 1'b1;
    for (int i = 0; i < NC; i++) begin
      repeat ($urandom_range(0, 3)) begin
        p_valid = 1'b0;
        p       = ($urandom_range(0, 1) == 1) ? 20'h7FFFF : 20'($urandom);
        @(posedge clk); #1;
      end
      if (i == NC - 1) begin
        n_checks++;
        if (class_valid !== 1'b0) begin n_fail++; $display("FAIL gap_early_valid: got %0b need 0", class_valid); end
      end
      send(basic_v[i]);
    end
    @(negedge clk);
    n_checks++;
    if (class_valid !== 1'b1 || class_idx !== 4'd2 || class_score !== 20'd12) begin
      n_fail++; $display("FAIL gap_result: valid=%0b idx=%0d score=%h need 1/2/0000c", class_valid, class_idx, class_score);
    end
    n_checks++;
    if (digit_cnt !== 8'd1) begin n_fail++; $display("FAIL gap_cnt: got %0d need 1", digit_cnt); end
    @(posedge clk); #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst         = 1'b0;
    p_valid     = 1'b0;
    p           = '0;
    class_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    test_reset();
    test_basic();
    test_extremes();
    test_back_pressure();
    test_continuous();
    test_reset_mid();
    test_gapped();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mac_argmax.md
# mac_argmax

Downstream classification stage for the pipelined MAC. Consumes the stream of signed 20-bit neuron scores `p` (one per output neuron, NUM_CLASSES consecutive scores per input digit) and tracks the running maximum. After the last neuron of a digit it emits the winning class index and score through a one-entry valid/ready output register. It applies back-pressure to the MAC feeder only when a completed result would overwrite a pending, unaccepted one.

## Interface
- `P_W`, 20: score width; matches MAC output `p`.
- `NUM_CLASSES`, 10: neuron scores per digit, valid range 2..16.
- `IDX_W`, 4: class index width; must satisfy 2^IDX_W >= NUM_CLASSES.
- `CNT_W`, 8: digit counter width.

Ports (bit 0 is MSB on all vectors, as on the MAC):
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset, **asynchronous, active-low**.
- `p_valid`  in  1  score `p` is valid this cycle.
- `p_ready`  out  1  block accepts `p`. A score is accepted when `p_valid && p_ready` at the rising edge.
- `p`  in  [0:P_W-1]  signed two's-complement neuron score.
- `class_valid`  out  1  result register holds an unconsumed result.
- `class_ready`  in  1  consumer takes the result when `class_valid && class_ready` at the rising edge.
- `class_idx`  out  [0:IDX_W-1]  winning neuron index, 0..NUM_CLASSES-1.
- `class_score`  out  [0:P_W-1]  signed score of the winner.
- `digit_cnt`  out  [0:CNT_W-1]  number of results produced since reset; wraps modulo 2^CNT_W.

## Operation
- **Internal registers:** `idx` (neuron position), `best`, `best_idx`.
- **FSM states:**
  - `S_FIRST`: `idx` = 0.
  - `S_REST`: 0 < `idx` < NUM_CLASSES-1.
  - `S_LAST`: `idx` = NUM_CLASSES-1.
  - State advances only on an accepted score. Otherwise state and `idx` hold.
- **Accept in `S_FIRST`:**
  - Load `best` = `p` and `best_idx` = 0.
  - Next state: `S_REST`, or `S_LAST` when NUM_CLASSES = 2.
- **Accept in `S_REST`:**
  - If `p` > `best` (signed, strict), load `best` = `p` and `best_idx` = `idx`.
  - Increment `idx`. Enter `S_LAST` when it reaches NUM_CLASSES-1.
- **Accept in `S_LAST`:**
  - Compute the final compare combinationally against the incoming `p`.
  - Load `class_idx` and `class_score` with the winner.
  - Set `class_valid` and increment `digit_cnt`.
  - Return to `S_FIRST` and clear `idx`.
- **Ties:** the lowest index wins, because the compare is strict.
- **Comparison:** full P_W-bit signed. No saturation, no truncation.
- **Ready rule:** `p_ready` = !(state == `S_LAST` && `class_valid` && !`class_ready`). It is combinational from registered state and `class_ready`, and never depends on `p_valid`.
- **Output register:**
  - `class_valid` clears when the result is taken and no new result loads in the same edge.
  - If a take and a load occur on the same edge, `class_valid` stays 1 and the new result replaces the old one.
- **Stability:** while `class_valid` = 1 and `class_ready` = 0, `class_idx` and `class_score` are stable.
- **Reset mid-digit:** discards the partial digit. No result is emitted for it.

## Timing
- **Reset values:**
  - `class_valid` = 0, `class_idx` = 0, `class_score` = 0, `digit_cnt` = 0.
  - State = `S_FIRST`, `idx` = 0, `best` = 0, `best_idx` = 0.
  - `p_ready` = 1.
- **Throughput:** one score per cycle sustained, with no bubble between digits when the consumer is always ready.
- **Latency:** last score accepted at edge k → `class_valid` = 1 with the result during cycle k+1.
- **Reset deassertion:** treated as synchronous to `clk` by the surrounding design. The first acceptance can occur on the first edge after release.
- **Data during stall:** `p` is ignored whenever `p_valid` = 0 or `p_ready` = 0.
- **Edge cases:**
  - All-equal scores → index 0.
  - Most-negative score (0x80000) is handled correctly as the minimum.
  - `digit_cnt` wraps from 255 to 0.

## Structure
- **Shared package `ann_pkg`:** P_W, NUM_CLASSES, IDX_W, CNT_W defaults, plus the FSM state encoding constants (`S_FIRST`, `S_REST`, `S_LAST`). The MAC and later stages reuse the widths.
- **Sub-module `signed_max_sel`:** combinational.
  - Inputs: candidate score/index and incumbent score/index.
  - Outputs: winner score/index, strict-greater rule.
  - Used for both the running update and the `S_LAST` final compare.
- **Top level:** FSM, counters and the output register.

## Test plan
1. **Reset then basic digit:** pulse `rst` low mid-run, then stream scores 5, -3, 12, 0, 7, 12, 1, 2, 3, 4 back-to-back with `class_ready` = 1 → `class_valid` one cycle after the 10th accept, `class_idx` = 2, `class_score` = 12, `digit_cnt` = 1. The tie at 12 resolves to index 2. Before reset release all outputs read 0 and `p_ready` = 1.
2. **All-negative and extreme values:** scores 0x80000, 0xFFFFF (-1), 0x80001, and 0x80000 for the rest → `class_idx` = 1, `class_score` = 0xFFFFF.
3. **Back-pressure:**
   - Digit A completes with `class_ready` = 0. Stream digit B.
   - Expect `p_ready` = 0 only while in `S_LAST` with A pending. B's 10th score is held, not lost.
   - Raise `class_ready` → A taken, B accepted on the same edge, B's result valid next cycle.
4. **Continuous stream:** 256 digits at full rate, consumer always ready → one result per 10 cycles, no stalls, `digit_cnt` wraps to 0 after the 256th result.
5. **Reset mid-digit:** assert `rst` after 6 accepted scores, release, then send a full digit → exactly one result, computed from the post-reset digit only.
6. **Gapped input:** random `p_valid` gaps, with garbage on `p` while `p_valid` = 0 → results identical to the gap-free run.
